uart_rx_framer: RTL



---
 rtl/uart_rx_framer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_framer.sv
// UART receive framer: synchronises rx, qualifies the start bit, majority-votes
// each bit at its centre and emits one-clk rx_valid / frame_err pulses.
module uart_rx_framer #(
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);
    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] VOTE_A   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] VOTE_B   = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] VOTE_C   = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] TICK_END = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic [1:0]             samp_q, samp_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   armed_q, armed_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   busy_q, busy_d;
    logic                   rx_s;
    logic                   vote;

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], rx};
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        samp_d  = samp_q;
        armed_d = armed_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        if (baud_en) begin
            if (state_q != IDLE) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == VOTE_A) samp_d[0] = rx_s;
                if (cnt_q == VOTE_B) samp_d[1] = rx_s;
            end
            case (state_q)
                IDLE: begin
                    if (rx_s) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        // The detecting tick is tick 0 of the start bit.
                        state_d = START;
                        cnt_d   = CW'(1);
                        armed_d = 1'b0;
                    end
                end
                START: begin
                    if (cnt_q == VOTE_C && vote) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TICK_END) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end
                end
                DATA: begin
                    if (cnt_q == VOTE_C) shift_d = {vote, shift_q[DATA_BITS-1:1]};
                    if (cnt_q == TICK_END) begin
                        cnt_d = '0;
                        if (idx_q == BIT_LAST) state_d = STOP;
                        else                   idx_d   = idx_q + 1'b1;
                    end
                end
                STOP: begin
                    // High stop samples re-arm so a start right after the vote is taken.
                    if (rx_s) armed_d = 1'b1;
                    if (cnt_q == VOTE_C) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        if (vote) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            samp_q  <= '0;
            sync_q  <= '1;
            armed_q <= 1'b0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            samp_q  <= samp_d;
            sync_q  <= sync_d;
            armed_q <= armed_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign data_out  = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;
endmodule
